dsa_modreduce: RTL and testbench

- Sequential bit-serial modular reduction, r = y mod q, for the DSA signing datapath.
- Sits directly downstream of the modular exponentiator. It consumes y = g^k mod p, captured when the exponentiator raises ready.
- Produces the signature component r, plus a flag when r = 0 so the controller can draw a new k.
- Uses the same ds/ready handshake as the exponentiator so the two chain without glue.

---
 rtl/dsa_modreduce_pkg.sv | 11 +
 rtl/dsa_modreduce_condsub.sv | 21 ++
 rtl/dsa_modreduce.sv | 117 +++++++++++
 tb/tb_dsa_modreduce.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_modreduce_pkg.sv
// Shared definitions for the DSA mod-q datapath: default width, counter width
// and FSM state encoding.
package dsa_modreduce_pkg;

  localparam int unsigned KEYSIZE_DEF = 32;
  localparam int unsigned CNTW        = $clog2(KEYSIZE_DEF + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/dsa_modreduce_condsub.sv
// One restoring-remainder step: subtract q from t when t >= q, else pass t.
// Compare and subtract are both W+1 bits wide.
module dsa_condsub
  import dsa_modreduce_pkg::*;
#(
  parameter int unsigned W = KEYSIZE_DEF
) (
  input  logic [W:0]   t,
  input  logic [W-1:0] q,
  output logic [W:0]   r
);

  // Conditional subtract of the zero-extended modulus
  always_comb begin
    r = t;
    if (t >= {1'b0, q}) begin
      r = t - {1'b0, q};
    end
  end

endmodule

// File: rtl/dsa_modreduce.sv
// Bit-serial modular reduction r = y mod q, with a ds/ready handshake that
// matches the modular exponentiator. Takes KEYSIZE clocks per operation;
// q == 0 completes on the accepting edge with divzero set.
module dsa_modreduce
  import dsa_modreduce_pkg::*;
#(
  parameter int unsigned KEYSIZE = KEYSIZE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEYSIZE-1:0] indata,
  input  logic [KEYSIZE-1:0] inMod,
  input  logic               ds,
  output logic [KEYSIZE-1:0] result,
  output logic               rzero,
  output logic               divzero,
  output logic               ready
);

  localparam int unsigned CW = $clog2(KEYSIZE + 1);

  logic [0:0]         state_q,   state_d;
  logic [KEYSIZE-1:0] rem_q,     rem_d;
  logic [KEYSIZE-1:0] shift_q,   shift_d;
  logic [KEYSIZE-1:0] qreg_q,    qreg_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [KEYSIZE-1:0] result_q,  result_d;
  logic               rzero_q,   rzero_d;
  logic               divzero_q, divzero_d;
  logic               ready_q,   ready_d;

  logic [KEYSIZE:0]   step_t;
  logic [KEYSIZE:0]   step_r;

  assign step_t = {rem_q, shift_q[KEYSIZE-1]};

  dsa_condsub #(.W(KEYSIZE)) u_condsub (
    .t (step_t),
    .q (qreg_q),
    .r (step_r)
  );

  // Next-state logic: accept in IDLE, one remainder step per clock in RUN
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    shift_d   = shift_q;
    qreg_d    = qreg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rzero_d   = rzero_q;
    divzero_d = divzero_q;
    ready_d   = ready_q;
    case (state_q)
      IDLE: begin
        if (ds && ready_q) begin
          shift_d = indata;
          qreg_d  = inMod;
          rem_d   = '0;
          cnt_d   = CW'(KEYSIZE);
          if (inMod == '0) begin
            result_d  = '0;
            rzero_d   = 1'b0;
            divzero_d = 1'b1;
          end else begin
            divzero_d = 1'b0;
            ready_d   = 1'b0;
            state_d   = RUN;
          end
        end
      end
      default: begin
        // rem < q holds after every step, so the top bit of step_r is zero
        rem_d   = step_r[KEYSIZE-1:0];
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = step_r[KEYSIZE-1:0];
          rzero_d  = (step_r == '0);
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      shift_q   <= '0;
      qreg_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      rzero_q   <= 1'b0;
      divzero_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      shift_q   <= shift_d;
      qreg_q    <= qreg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      rzero_q   <= rzero_d;
      divzero_q <= divzero_d;
      ready_q   <= ready_d;
    end
  end

  assign result  = result_q;
  assign rzero   = rzero_q;
  assign divzero = divzero_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_dsa_modreduce.sv
// Self-checking bench for dsa_modreduce: expected results are pushed to a
// scoreboard queue when a request is driven and popped at completion.
module tb_dsa_modreduce;

  typedef struct packed {
    logic [31:0] res;
    logic        rz;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] indata;
  logic [31:0] inMod;
  logic        ds;
  logic [31:0] result;
  logic        rzero;
  logic        divzero;
  logic        ready;

  int   checks;
  int   errors;
  exp_t sb[$];

  dsa_modreduce #(.KEYSIZE(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .indata  (indata),
    .inMod   (inMod),
    .ds      (ds),
    .result  (result),
    .rzero   (rzero),
    .divzero (divzero),
    .ready   (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [31:0] y, input logic [31:0] q);
    exp_t e;
    if (q == 32'd0) begin
      e.res = 32'd0;
      e.rz  = 1'b0;
      e.dz  = 1'b1;
    end else begin
      e.res = y % q;
      e.rz  = (e.res == 32'd0);
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  // Drive one request (caller guarantees ready=1), return ready just after
  // the accepting edge and the number of further edges until ready is high.
  task automatic run_op(input logic [31:0] y, input logic [31:0] q,
                        output logic rdy0, output int lat);
    indata = y;
    inMod  = q;
    ds     = 1'b1;
    @(posedge clk); #1;
    ds   = 1'b0;
    rdy0 = ready;
    lat  = 0;
    while (ready !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    indata = 32'd5;
    inMod  = 32'd3;
    for (int i = 0; i < 3; i++) begin
      ds = ~ds;
      @(negedge clk);
      checks++;
      if ({ready, result, rzero, divzero} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got rdy=%b res=%h rz=%b dz=%b want 1/0/0/0",
                 i, ready, result, rzero, divzero);
      end
    end
    ds    = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, result, rzero, divzero} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b res=%h rz=%b dz=%b want 1/0/0/0",
               ready, result, rzero, divzero);
    end
  endtask

  task automatic test_basic();
    logic r0; int lat; exp_t e;
    @(posedge clk); #1;
    sb.push_back(model(32'd100, 32'd7));
    run_op(32'd100, 32'd7, r0, lat);
    e = sb.pop_front();
    checks++;
    if (r0 !== 1'b0) begin
      errors++; $display("FAIL basic_busy: ready=%b want 0", r0);
    end
    checks++;
    if (lat != 32) begin
      errors++; $display("FAIL basic_latency: got %0d want 32", lat);
    end
    checks++;
    if ({result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
      errors++;
      $display("FAIL basic_result: got %h/%b/%b want %h/%b/%b",
               result, rzero, divzero, e.res, e.rz, e.dz);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({ready, result} !== {1'b1, e.res}) begin
      errors++;
      $display("FAIL basic_hold: got rdy=%b res=%h want 1/%h", ready, result, e.res);
    end
  endtask

  // Second request is issued on the first cycle ready is high
  task automatic test_fullwidth_zero();
    logic [31:0] ys [2] = '{32'hFFFF_FFFF, 32'd21};
    logic [31:0] qs [2] = '{32'hFFFF_FFFB, 32'd7};
    logic r0; int lat; exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(ys[i], qs[i]));
      run_op(ys[i], qs[i], r0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != 32 || {result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
        errors++;
        $display("FAIL fullwidth[%0d]: got lat=%0d %h/%b/%b want lat=32 %h/%b/%b",
                 i, lat, result, rzero, divzero, e.res, e.rz, e.dz);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] ys [6] = '{32'd5, 32'd9, 32'd0, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] qs [6] = '{32'd9, 32'd9, 32'd3, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000};
    logic r0; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(ys[i], qs[i]));
      run_op(ys[i], qs[i], r0, lat);
      e = sb.pop_front();
      checks++;
      if (lat != 32 || {result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
        errors++;
        $display("FAIL boundary[%0d]: got lat=%0d %h/%b/%b want lat=32 %h/%b/%b",
                 i, lat, result, rzero, divzero, e.res, e.rz, e.dz);
      end
    end
  endtask

  task automatic test_divzero();
    logic r0; int lat; exp_t e;
    sb.push_back(model(32'h1234, 32'd0));
    run_op(32'h1234, 32'd0, r0, lat);
    e = sb.pop_front();
    checks++;
    if (r0 !== 1'b1 || lat != 0) begin
      errors++; $display("FAIL divzero_ready: got rdy0=%b lat=%0d want 1/0", r0, lat);
    end
    checks++;
    if ({result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
      errors++;
      $display("FAIL divzero_flags: got %h/%b/%b want %h/%b/%b",
               result, rzero, divzero, e.res, e.rz, e.dz);
    end
    sb.push_back(model(32'd100, 32'd7));
    run_op(32'd100, 32'd7, r0, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 32 || {result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
      errors++;
      $display("FAIL divzero_clear: got lat=%0d %h/%b/%b want lat=32 %h/%b/%b",
               lat, result, rzero, divzero, e.res, e.rz, e.dz);
    end
  endtask

  task automatic test_ds_during_run();
    int lat; exp_t e;
    sb.push_back(model(32'd100, 32'd7));
    indata = 32'd100; inMod = 32'd7; ds = 1'b1;
    @(posedge clk); #1;
    ds  = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    indata = 32'h0000_FFFF; inMod = 32'd3; ds = 1'b1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    ds = 1'b0;
    while (ready !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (lat != 32 || {result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
      errors++;
      $display("FAIL ds_during_run: got lat=%0d %h/%b/%b want lat=32 %h/%b/%b",
               lat, result, rzero, divzero, e.res, e.rz, e.dz);
    end
  endtask

  task automatic test_reset_abort();
    logic r0; int lat; exp_t e;
    indata = 32'd100; inMod = 32'd7; ds = 1'b1;
    @(posedge clk); #1;
    ds = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ready, result, rzero, divzero} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_async: got rdy=%b res=%h rz=%b dz=%b want 1/0/0/0",
               ready, result, rzero, divzero);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(32'd1000, 32'd13));
    run_op(32'd1000, 32'd13, r0, lat);
    e = sb.pop_front();
    checks++;
    if (lat != 32 || {result, rzero, divzero} !== {e.res, e.rz, e.dz}) begin
      errors++;
      $display("FAIL abort_fresh: got lat=%0d %h/%b/%b want lat=32 %h/%b/%b",
               lat, result, rzero, divzero, e.res, e.rz, e.dz);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    ds     = 1'b0;
    indata = '0;
    inMod  = '0;
    test_reset();
    test_basic();
    test_fullwidth_zero();
    test_boundaries();
    test_divzero();
    test_ds_during_run();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
